// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
//   Shared definitions for the key debouncer:
//     - key_state_t        : debounce FSM state encoding
//     - DEBOUNCE_COUNT_DEF : default number of qualifying ticks (4)
//     - GLITCH_W_DEF       : default glitch counter width (8)
//     - state_outkey()     : debounced level implied by a given FSM state
// -----------------------------------------------------------------------------
package key_pkg;

  localparam int DEBOUNCE_COUNT_DEF = 4;
  localparam int GLITCH_W_DEF       = 8;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } key_state_t;

  // The debounced level is a pure function of the state: high while the key
  // is accepted as pressed, including while a release is being qualified.
  function automatic logic state_outkey(input key_state_t state);
    return (state == STABLE_HIGH) || (state == CHECK_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level. Output is valid two
//   clock edges after the input settles.
//   Ports:
//     clock : system clock
//     reset : synchronous, active-high reset; both flops clear to 0
//     i_d   : asynchronous input level
//     o_q   : synchronized level (second flop output)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Debounces a bouncing mechanical key. The raw level is synchronized, then a
//   four-state FSM requires DEBOUNCE_COUNT consecutive ticks of a stable new
//   level before the registered output follows it. Any reversal while a new
//   level is being qualified aborts the attempt.
//
//   Parameters:
//     DEBOUNCE_COUNT : qualifying ticks required to change outkey (1..255)
//     GLITCH_W       : width of the aborted-attempt counter
//   Ports:
//     clock      : system clock, all state changes on its rising edge
//     reset      : synchronous, active-high reset
//     rawkey     : asynchronous, bouncing key level
//     tick       : single-cycle sample strobe (held high = count every cycle)
//     outkey     : registered debounced key level
//     glitch_cnt : saturating count of aborted debounce attempts
//
//   Build option:
//     KEY_DEBOUNCE_GLITCH_CNT_EN : when defined, the glitch counter is built;
//                                  otherwise glitch_cnt is tied to 0.
// -----------------------------------------------------------------------------
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF,
  parameter int GLITCH_W       = GLITCH_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rawkey,
  input  logic                tick,
  output logic                outkey,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

  logic             w_sync_key;
  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_outkey;

  sync_2ff u_sync_2ff (
    .clock (clock),
    .reset (reset),
    .i_d   (rawkey),
    .o_q   (w_sync_key)
  );

  // outkey is decoded from the next state and registered, so it changes on the
  // same edge the FSM settles and is a clean flop output.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      r_state  <= STABLE_LOW;
      r_cnt    <= '0;
      r_outkey <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_outkey <= state_outkey(w_state_nxt);
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed
    // branch would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;

    unique case (r_state)
      STABLE_LOW: begin
        // A tick in the entry cycle is deliberately not counted.
        if (w_sync_key) begin
          w_state_nxt = CHECK_HIGH;
          w_cnt_nxt   = '0;
        end
      end

      CHECK_HIGH: begin
        // Reversal is checked before tick so it wins a same-cycle collision.
        if (!w_sync_key) begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
        end else if (tick) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = STABLE_HIGH;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      STABLE_HIGH: begin
        if (!w_sync_key) begin
          w_state_nxt = CHECK_LOW;
          w_cnt_nxt   = '0;
        end
      end

      CHECK_LOW: begin
        if (w_sync_key) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (tick) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = STABLE_LOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = STABLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign outkey = r_outkey;

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
  logic                w_abort;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  // An abort is any reversal seen while a new level is being qualified.
  // Reset clears the count without scoring the interrupted attempt.
  assign w_abort = ((r_state == CHECK_HIGH) && !w_sync_key) ||
                   ((r_state == CHECK_LOW)  &&  w_sync_key);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_glitch_cnt <= '0;
    end else if (w_abort && (r_glitch_cnt != '1)) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter: DEBOUNCE_COUNT, default 4, number of consecutive qualifying ticks of stable input required before outkey changes; legal range 1..255.
REQ-002 Parameter: GLITCH_W, default 8, width of the glitch counter.
REQ-003 Port: clock  input  1  system clock; all state changes on posedge clock.
REQ-004 Port: reset  input  1  synchronous, active-high reset; clock clock.
REQ-005 Port: rawkey  input  1  asynchronous, bouncing mechanical key level.
REQ-006 Port: tick  input  1  single-cycle sample strobe (e.g. 1 kHz); held high means count every cycle.
REQ-007 Port: outkey  output  1  registered debounced key level; feeds the downstream rising-edge pulse shaper.
REQ-008 Port: glitch_cnt  output  GLITCH_W  saturating count of aborted debounce attempts.

Function
REQ-009 rawkey SHALL pass through a two-flop synchronizer; sync_key is the second flop output, 2-cycle latency.
REQ-010 FSM states SHALL be STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW; outkey=0 in STABLE_LOW/CHECK_HIGH, 1 in STABLE_HIGH/CHECK_LOW.
REQ-011 STABLE_LOW with sync_key=1 SHALL go to CHECK_HIGH and clear the tick counter; a tick in that same cycle SHALL NOT count.
REQ-012 CHECK_HIGH with sync_key=0 SHALL return to STABLE_LOW, clear the counter and increment glitch_cnt.
REQ-013 CHECK_HIGH with sync_key=1 and tick=1 SHALL increment the counter; if the counter equals DEBOUNCE_COUNT-1, go to STABLE_HIGH and set outkey=1 at that same edge.
REQ-014 STABLE_HIGH/CHECK_LOW SHALL mirror REQ-011..013 with polarities inverted (outkey cleared on leaving CHECK_LOW to STABLE_LOW).
REQ-015 sync_key reversal and tick in the same cycle: reversal SHALL win; no count, glitch counted.
REQ-016 Counter width SHALL be $clog2(DEBOUNCE_COUNT+1); counter SHALL never exceed DEBOUNCE_COUNT-1.
REQ-017 glitch_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-018 outkey SHALL change at most once per DEBOUNCE_COUNT qualifying ticks and SHALL be glitch-free (direct flop output).

Reset
REQ-019 Reset SHALL force state STABLE_LOW, outkey=0, counter=0, glitch_cnt=0, both synchronizer flops 0.
REQ-020 Reset asserted mid-CHECK SHALL abort the debounce without incrementing glitch_cnt; reset has priority over all events.

Configuration
REQ-021 Macro KEY_DEBOUNCE_GLITCH_CNT_EN defined: glitch counter logic per REQ-012/017 is compiled in.
REQ-022 Macro undefined: counter logic is omitted, glitch_cnt port remains and SHALL be tied to 0; all other behaviour unchanged.

Structure
REQ-023 Shared package key_pkg SHALL hold the FSM state enum type and the default constants DEBOUNCE_COUNT_DEF=4, GLITCH_W_DEF=8.
REQ-024 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset to 0), instantiated once.

Verification (DEBOUNCE_COUNT=4, tick every 10th cycle)
REQ-025 Reset released, rawkey=0 for 100 cycles -> outkey=0, glitch_cnt=0 throughout.
REQ-026 rawkey 0->1 held stable -> outkey rises at the edge of the 4th tick after CHECK_HIGH entry, never earlier.
REQ-027 rawkey toggles 1,0 with 3-cycle periods for 30 cycles then settles 0 -> outkey stays 0, glitch_cnt equals the number of aborted CHECK_HIGH entries.
REQ-028 outkey=1, rawkey drops for 3 ticks then returns high -> outkey stays 1, glitch_cnt +1.
REQ-029 Reset asserted during CHECK_HIGH after 2 ticks -> next cycle outkey=0, counter=0, glitch_cnt=0; re-debounce needs a full 4 ticks.
REQ-030 tick tied high, 300 forced aborts with macro defined -> glitch_cnt=255 (saturated); with macro undefined -> glitch_cnt=0.
